// File: rtl/seg_scan_driver.sv
// Eight-digit seven-segment scan driver: hex or unsigned decimal rendering of a
// 32-bit value, with a double-dabble engine feeding the decimal display.
module seg_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] data,
    input  logic        base,
    output logic [7:0]  digit_en,
    output logic [7:0]  sseg,
    output logic [7:0]  sseg1,
    output logic [1:0]  o_dbg_state
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [4:0] CODE_DASH  = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_idx;
    logic [31:0]      r_hex_q;

    state_t           r_state;
    logic [31:0]      r_last_conv;
    logic [31:0]      r_bin_sh;
    logic [39:0]      r_bcd;
    logic [4:0]       r_cnt;
    logic [31:0]      r_dec_q;
    logic             r_dec_ovf;

    logic [39:0]      w_bcd_adj;
    logic [3:0]       w_hex_nib;
    logic [3:0]       w_dec_nib;
    logic             w_dec_upper_zero;
    logic [4:0]       w_code;
    logic [7:0]       w_pat;

    function automatic logic [7:0] seg_pat(input logic [4:0] code);
        case (code)
            5'd0:    seg_pat = 8'hFC;
            5'd1:    seg_pat = 8'h60;
            5'd2:    seg_pat = 8'hDA;
            5'd3:    seg_pat = 8'hF2;
            5'd4:    seg_pat = 8'h66;
            5'd5:    seg_pat = 8'hB6;
            5'd6:    seg_pat = 8'hBE;
            5'd7:    seg_pat = 8'hE0;
            5'd8:    seg_pat = 8'hFE;
            5'd9:    seg_pat = 8'hF6;
            5'd10:   seg_pat = 8'hEE;
            5'd11:   seg_pat = 8'h3E;
            5'd12:   seg_pat = 8'h9C;
            5'd13:   seg_pat = 8'h7A;
            5'd14:   seg_pat = 8'h9E;
            5'd15:   seg_pat = 8'h8E;
            5'd16:   seg_pat = 8'h02;
            default: seg_pat = 8'h00;
        endcase
    endfunction

    // Scan timing runs freely; the conversion engine never stalls it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_div_cnt <= '0;
            r_idx     <= 3'd0;
            r_hex_q   <= 32'd0;
        end else begin
            r_hex_q <= data;
            if (r_div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                r_div_cnt <= '0;
                r_idx     <= r_idx + 3'd1;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < 10; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_last_conv <= 32'd0;
            r_bin_sh    <= 32'd0;
            r_bcd       <= 40'd0;
            r_cnt       <= 5'd0;
            r_dec_q     <= 32'd0;
            r_dec_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (base && (data != r_last_conv)) begin
                        r_bin_sh    <= data;
                        r_last_conv <= data;
                        r_bcd       <= 40'd0;
                        r_cnt       <= 5'd0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd    <= 40'({w_bcd_adj, r_bin_sh[31]});
                    r_bin_sh <= {r_bin_sh[30:0], 1'b0};
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= COMMIT;
                end
                COMMIT: begin
                    r_dec_q   <= r_bcd[31:0];
                    r_dec_ovf <= |r_bcd[39:32];
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_dbg_state = r_state;

    assign w_hex_nib        = r_hex_q[{r_idx, 2'b00} +: 4];
    assign w_dec_nib        = r_dec_q[{r_idx, 2'b00} +: 4];
    // Digit is a leading zero when it and everything above it is zero.
    assign w_dec_upper_zero = ((r_dec_q >> {r_idx, 2'b00}) == 32'd0);

    always_comb begin
        if (!base)
            w_code = {1'b0, w_hex_nib};
        else if (r_dec_ovf)
            w_code = CODE_DASH;
        else if ((r_idx != 3'd0) && w_dec_upper_zero)
            w_code = CODE_BLANK;
        else
            w_code = {1'b0, w_dec_nib};
    end

    assign w_pat = seg_pat(w_code);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            digit_en <= 8'h00;
            sseg     <= 8'h00;
            sseg1    <= 8'h00;
        end else begin
            digit_en <= 8'd1 << r_idx;
            if (!r_idx[2]) begin
                sseg  <= w_pat;
                sseg1 <= 8'h00;
            end else begin
                sseg  <= 8'h00;
                sseg1 <= w_pat;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4: scan order, hex and
// decimal rendering, overflow, mid-conversion data change and reset abort.
module tb_seg_scan_driver;

    logic        clk;
    logic        rstn;
    logic [31:0] data;
    logic        base;
    logic [7:0]  digit_en;
    logic [7:0]  sseg;
    logic [7:0]  sseg1;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_fail;

    seg_scan_driver #(.SCAN_DIV(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .data        (data),
        .base        (base),
        .digit_en    (digit_en),
        .sseg        (sseg),
        .sseg1       (sseg1),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until digit k is enabled, then compare both segment buses.
    task automatic chk_digit(input string tag, input int k, input logic [7:0] exp_pat);
        logic [7:0] want_en;
        int waited;
        want_en = 8'd1 << k;
        waited = 0;
        while (digit_en !== want_en && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (digit_en !== want_en) begin
            chk($sformatf("%s_timeout_d%0d", tag, k), {24'd0, digit_en}, {24'd0, want_en});
        end else if (k < 4) begin
            chk($sformatf("%s_d%0d", tag, k), {16'd0, sseg1, sseg}, {16'd0, 8'h00, exp_pat});
        end else begin
            chk($sformatf("%s_d%0d", tag, k), {16'd0, sseg1, sseg}, {16'd0, exp_pat, 8'h00});
        end
    endtask

    // exp holds digit 7 in the top byte down to digit 0 in the bottom byte.
    task automatic chk_frame(input string tag, input logic [63:0] exp);
        for (int k = 0; k < 8; k++)
            chk_digit(tag, k, exp[8*k +: 8]);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn = 1'b0;
        data = 32'd0;
        base = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {8'd0, digit_en, sseg, sseg1}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);

        // Scan sequence, each digit held 4 cycles, all zeros in hex
        rstn = 1'b1;
        for (int c = 0; c < 33; c++) begin
            logic [7:0] en_exp;
            int di;
            @(negedge clk);
            di = (c / 4) % 8;
            en_exp = 8'd1 << di;
            chk($sformatf("scan_en_c%0d", c), {24'd0, digit_en}, {24'd0, en_exp});
            if (di < 4)
                chk($sformatf("scan_seg_c%0d", c), {16'd0, sseg1, sseg}, {16'd0, 8'h00, 8'hFC});
            else
                chk($sformatf("scan_seg_c%0d", c), {16'd0, sseg1, sseg}, {16'd0, 8'hFC, 8'h00});
        end

        // Hex rendering
        data = 32'h1234ABCD;
        repeat (2) @(negedge clk);
        chk_frame("hex", 64'h60DAF266EE3E9C7A);

        // Decimal 305 with exact FSM latency
        base = 1'b1;
        data = 32'd305;
        @(negedge clk);
        chk("dec_start_shift", {30'd0, dbg_state}, 32'd1);
        repeat (32) @(negedge clk);
        chk("dec_commit", {30'd0, dbg_state}, 32'd2);
        @(negedge clk);
        chk("dec_back_idle", {30'd0, dbg_state}, 32'd0);
        chk_frame("dec305", 64'h00000000_00F2FCB6);

        // Overflow, then largest displayable value
        data = 32'd100000000;
        repeat (40) @(negedge clk);
        chk_frame("ovf", 64'h02020202_02020202);
        data = 32'd99999999;
        repeat (40) @(negedge clk);
        chk_frame("max", 64'hF6F6F6F6_F6F6F6F6);

        // Data change during SHIFT: 7 commits first, then 42 reconverts
        data = 32'd7;
        @(negedge clk);
        repeat (10) @(negedge clk);
        data = 32'd42;
        repeat (24) @(negedge clk);
        chk("midchg_restart", {30'd0, dbg_state}, 32'd1);
        chk_digit("midchg7", 0, 8'hE0);
        chk_digit("midchg7", 1, 8'h00);
        repeat (40) @(negedge clk);
        chk_frame("dec42", 64'h00000000_000066DA);

        // Reset during SHIFT abandons the conversion
        data = 32'd12345;
        @(negedge clk);
        chk("abort_shift", {30'd0, dbg_state}, 32'd1);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        data = 32'd0;
        @(negedge clk);
        chk("abort_outputs", {8'd0, digit_en, sseg, sseg1}, 32'd0);
        chk("abort_state", {30'd0, dbg_state}, 32'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {30'd0, dbg_state}, 32'd0);
        chk_frame("zero", 64'h00000000_000000FC);
        chk("post_rst_still_idle", {30'd0, dbg_state}, 32'd0);

        // Back to hex: zeros are never blanked
        base = 1'b0;
        @(negedge clk);
        chk_frame("hex0", 64'hFCFCFCFC_FCFCFCFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's 8-digit seven-segment display. It accepts the 32-bit value held by the LED/segment output controller plus a base select, and renders it as 8 hex digits or as an unsigned decimal number. Decimal conversion is a sequential shift-add-3 (double-dabble) engine. The block produces one-hot digit enables and two segment buses: `sseg` for digits 0–3 and `sseg1` for digits 4–7. It sits directly downstream of the memory-mapped LED/segment register block and drives board pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each digit stays enabled; legal range ≥2.
- `clk` in, 1 bit: system clock. Single clock domain.
- `rstn` in, 1 bit: reset, synchronous and active-low.
- `data` in, 32 bits: value to display, held stable by the upstream register.
- `base` in, 1 bit: 0 selects hex, 1 selects unsigned decimal.
- `digit_en` out, 8 bits: active-high, one-hot digit enable. Bit i enables digit i; digit 0 is the rightmost.
- `sseg` out, 8 bits: segment pattern for digits 0–3, active-high, ordered {a,b,c,d,e,f,g,dp}.
- `sseg1` out, 8 bits: segment pattern for digits 4–7, same encoding.

## Operation
- **Scan**
  - Counter `div_cnt` runs 0..SCAN_DIV-1.
  - When it wraps, scan index `idx` (3 bits) increments, wrapping from 7 to 0.
  - `digit_en` = 1<<idx.
  - When idx<4, `sseg` = pattern(digit idx) and `sseg1` = 0x00. Otherwise `sseg1` = pattern(digit idx) and `sseg` = 0x00.
- **Patterns**
  - Digits 0–9: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6.
  - Hex letters: A=EE, b=3E, C=9C, d=7A, E=9E, F=8E.
  - '-' = 02; blank = 00.
  - dp is always 0.
- **Hex path**
  - Register `hex_q` loads `data` every cycle.
  - Digit i = `hex_q[4i+3:4i]`. All 8 digits are shown with no blanking.
- **Decimal path FSM**
  - States: IDLE, SHIFT, COMMIT.
  - IDLE: when `base`=1 and `data` differs from `last_conv`, capture `data` into `bin_sh` and `last_conv`, clear the 40-bit BCD accumulator, set `cnt`=0, and go to SHIFT.
  - SHIFT: on each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin_sh} left by 1. `cnt` increments. After 32 shifts (`cnt`==31 processed), go to COMMIT.
  - COMMIT: load `dec_q` from the accumulator. Set `dec_ovf` = (BCD digits 8 or 9 nonzero). Return to IDLE.
  - `data` changing during SHIFT does not abort the conversion. The mismatch is detected in IDLE and a new conversion starts.
  - While `base`=0 the FSM stays in IDLE. `last_conv` is kept, so switching back with unchanged `data` does not reconvert.
- **Decimal display**
  - If `dec_ovf`=1 (value ≥100000000), all 8 digits show '-'.
  - Otherwise, leading-zero digits above the most significant nonzero digit are blank. Digit 0 always shows, so 0 displays as a single "0".
  - Until a COMMIT occurs, the display shows the previously committed value.
- **Reset**
  - Register reset values: `div_cnt`=0, `idx`=0, `hex_q`=0, `last_conv`=0, `dec_q`=0, `dec_ovf`=0, FSM=IDLE.
  - Output reset values: `digit_en`=00, `sseg`=00, `sseg1`=00.
  - Because `last_conv` resets to 0 and `dec_q` to 0, the display after reset is consistent with `data`=0 without a conversion.
  - `rstn` low mid-conversion abandons the conversion. `dec_q` returns to 0.

## Timing
- All outputs are registered and are computed from current `idx`, `hex_q`, `dec_q` and `dec_ovf`.
- The first clock edge with `rstn`=1 produces `digit_en`=01.
- Scan: each digit is enabled for exactly SCAN_DIV cycles. A full frame is 8×SCAN_DIV cycles.
- Hex latency:
  - `data` change sampled at edge N → `hex_q` updated at N → outputs reflect it at edge N+1, provided that digit is being scanned.
  - `base` change takes effect on outputs at the next edge.
- Decimal latency:
  - Mismatch seen in IDLE at edge N → SHIFT cycles at N+1..N+32 → COMMIT at N+33 → outputs change at N+34.
  - Back-to-back conversions are separated by at least 1 IDLE cycle.
- `idx` advancement is independent of the FSM. Conversion never stalls the scan.

## Test plan
- Reset with `data`=0, `base`=0, SCAN_DIV=4, then release `rstn` → `digit_en` steps 01,02,…,80,01, each held for 4 cycles. `sseg`=FC for idx 0–3 with `sseg1`=00; `sseg1`=FC for idx 4–7.
- Hex: `data`=0x1234ABCD, `base`=0 → digits 0..7 show D,C,B,A,4,3,2,1, i.e. `sseg`=7A,9C,3E,EE then `sseg1`=66,F2,DA,60.
- Decimal: `data`=305, `base`=1 → after 34 cycles, digits 0–2 show 5,0,3 (B6,FC,F2) and digits 3–7 show 00. Leading zeros are blanked; the interior zero is shown.
- Overflow: `data`=100000000 in decimal mode → all digits 02. Then `data`=99999999 → all digits F6 after the next conversion.
- Mid-conversion change: `data`=7, then `data`=42 at cycle 10 of SHIFT → 7 is committed first, then 42 is committed by 35 cycles later. Final display is 2 at digit 0 (DA) and 4 at digit 1 (66).
- `rstn` asserted during SHIFT → all outputs 00 next edge, FSM in IDLE. After release with `data`=0 and `base`=1, the display shows a single "0" and no conversion starts.
